reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side companion of the 4x16-bit register group: accepts ALU results tagged with a destination index and buffers them in a 2-entry FIFO.
- Drains one entry per cycle as a one-hot register write enable plus write data, which connect directly to the register group's per-register enables and shared data input.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards before reading operands.

Parameters:
DATA_W, 16, width of result data and register contents
NREG, 4, number of registers (index width 2; design fixed at 4)
DEPTH, 2, write-buffer entries

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
en_in  input  1  result valid from ALU
wb_rd  input  2  destination register index of result
wb_data  input  16  result data
wb_ready  output  1  buffer can accept (count < DEPTH)
issue_en  input  1  decode reserves a destination this cycle
issue_rd  input  2  reserved destination index
stall  input  1  hold draining (buffer still accepts)
reg_en  output  4  one-hot register write enable to register group
d_out  output  16  write data to register group
en_out  output  1  high in the cycle a write is presented on reg_en/d_out
busy  output  4  busy[i]=1 while register i has an outstanding write

Behaviour:
- Reset (rst=0, async): FIFO emptied, count=0, reg_en=0, d_out=0, en_out=0, all pending counters 0 so busy=0. Reset mid-operation discards buffered entries and reservations; no write is presented after release until a new push.
- wb_ready is combinational: 1 iff count<2. It does not look ahead to a same-cycle pop, so a full buffer refuses a push even while draining.
- Push: at an edge with en_in=1 and wb_ready=1, {wb_rd,wb_data} is written at the tail. en_in with wb_ready=0 is dropped; the ALU must hold.
- Pop: at an edge with count>0 and stall=0, the head is removed. Registered outputs load reg_en<=onehot(head.rd), d_out<=head.data, en_out<=1.
- Idle: at an edge with no pop, reg_en<=0 and en_out<=0; d_out holds its last value.
- Push and pop at the same edge: count unchanged. At count=1 the new entry becomes head after the pop.
- No bypass: a push at edge N pops no earlier than N+1. reg_en/en_out are high from N+1 to N+2, and the register group captures at N+2. Minimum latency is 2 edges from en_in sample to register update.
- Ordering: strict FIFO. Two entries to the same index write back-to-back, and the later value remains.
- At most one bit of reg_en is set; en_out equals the OR of reg_en.
- Scoreboard: one 2-bit pending counter per register.
  - inc[i] = issue_en && issue_rd==i.
  - dec[i] = reg_en[i] (the write committing at this edge).
  - inc and dec together: unchanged.
  - inc alone at 3: saturates at 3.
  - dec alone at 0: stays 0 (untracked write allowed).
  - busy[i] = (cnt[i]!=0), registered-derived, no combinational path from inputs.
- stall only blocks pops. Pending counters keep incrementing during stall; busy stays set until the write commits.

Test Plan:
- Reset: drive rst=0 mid-stream with 2 buffered entries and busy=0101 -> reg_en=0, d_out=0, en_out=0, busy=0000, wb_ready=1. After release, no write is presented without a new en_in.
- Single write latency: issue_en with issue_rd=2 at edge 0, then en_in with wb_rd=2, wb_data=16'hBEEF at edge 1.
  - busy[2]=1 after edge 0.
  - reg_en=0100, d_out=BEEF, en_out=1 during the cycle after edge 2.
  - busy[2]=0 after edge 3.
- Full and backpressure: stall=1, push 16'h0001 to r0 and 16'h0002 to r1 -> wb_ready=0, and a third en_in (r3, 16'h0003) is not accepted. After stall=0, writes drain r0/0001 then r1/0002 on consecutive cycles, and wb_ready returns to 1.
- Continuous streaming: en_in every cycle to r0,r1,r2,r3 with data 10,11,12,13 and stall=0 -> reg_en 0001,0010,0100,1000 on consecutive cycles with matching data and no drops.
- Same-register ordering and counters: issue r1 twice, then push r1/AAAA and r1/5555.
  - cnt[1]=2.
  - Writes appear AAAA then 5555.
  - busy[1] stays 1 until the second commit, then 0.
- Simultaneous inc/dec: issue r3 in the same cycle that reg_en[3]=1 commits a prior r3 write -> busy[3] stays 1 and cnt[3] unchanged. Four issues to r0 with no writes -> cnt saturates at 3.

Source files
------------

// File: rtl/reg_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_if
// Description : Bundle of the write-back path signals between the ALU and
//               decode side (master) and the write-back buffer (slave).
//               ALU side   : en_in, wb_rd, wb_data -> wb_ready
//               Decode side: issue_en, issue_rd, stall -> busy
//               Reg group  : reg_en (one-hot), d_out, en_out
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_writeback_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4
);
    localparam int c_IDX_W = $clog2(NREG);

    logic                en_in;
    logic [c_IDX_W-1:0]  wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_ready;
    logic                issue_en;
    logic [c_IDX_W-1:0]  issue_rd;
    logic                stall;
    logic [NREG-1:0]     reg_en;
    logic [DATA_W-1:0]   d_out;
    logic                en_out;
    logic [NREG-1:0]     busy;

    modport master (
        output en_in, wb_rd, wb_data, issue_en, issue_rd, stall,
        input  wb_ready, reg_en, d_out, en_out, busy
    );

    modport slave (
        input  en_in, wb_rd, wb_data, issue_en, issue_rd, stall,
        output wb_ready, reg_en, d_out, en_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : Write-side companion of the register group. Buffers tagged
//               ALU results in a small FIFO and drains one entry per cycle
//               as a one-hot register write enable plus shared write data.
//               A per-register pending counter tracks reserved destinations
//               so decode can detect RAW hazards.
// Ports       : clk  - clock, all state on the rising edge
//               rst  - asynchronous active-low reset
//               bus  - reg_writeback_if slave modport (ALU push, decode
//                      issue/stall/busy, register-group write outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int DEPTH  = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    reg_writeback_if.slave   bus
);
    localparam int c_IDX_W = $clog2(NREG);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [NREG-1:0]    c_ONEHOT0  = NREG'(1);

    // FIFO storage and control
    logic [c_IDX_W-1:0] r_fifo_rd   [DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Registered write port toward the register group
    logic [NREG-1:0]    r_reg_en;
    logic [DATA_W-1:0]  r_d_out;
    logic               r_en_out;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic [NREG-1:0]    w_head_onehot;
    logic [NREG-1:0]    w_busy;

    function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + c_PTR_ONE;
    endfunction

    // Readiness looks only at current occupancy: a full buffer refuses a push
    // even in a cycle where it is draining, which keeps wb_ready free of any
    // path from stall.
    assign w_ready       = (r_count < c_DEPTH);
    assign w_push        = bus.en_in && w_ready;
    assign w_pop         = (r_count != '0) && !bus.stall;
    assign w_head_onehot = c_ONEHOT0 << r_fifo_rd[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_rd[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_rd[r_wr_ptr]   <= bus.wb_rd;
                r_fifo_data[r_wr_ptr] <= bus.wb_data;
                r_wr_ptr              <= f_ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // The entry being removed is presented for exactly one cycle; d_out keeps
    // its last value when idle so the shared data bus does not toggle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_en <= '0;
            r_d_out  <= '0;
            r_en_out <= 1'b0;
        end else if (w_pop) begin
            r_reg_en <= w_head_onehot;
            r_d_out  <= r_fifo_data[r_rd_ptr];
            r_en_out <= 1'b1;
        end else begin
            r_reg_en <= '0;
            r_en_out <= 1'b0;
        end
    end

    // Pending-write scoreboard: one saturating 2-bit counter per register.
    // A write committing (reg_en high at this edge) retires one reservation;
    // a commit with nothing reserved is tolerated and leaves the counter at 0.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
        logic       w_inc;
        logic       w_dec;
        logic [1:0] r_pend;

        assign w_inc = bus.issue_en && (bus.issue_rd == c_IDX_W'(gi));
        assign w_dec = r_reg_en[gi];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pend <= 2'd0;
            end else if (w_inc && !w_dec) begin
                if (r_pend != 2'd3) begin
                    r_pend <= r_pend + 2'd1;
                end
            end else if (w_dec && !w_inc) begin
                if (r_pend != 2'd0) begin
                    r_pend <= r_pend - 2'd1;
                end
            end
        end

        assign w_busy[gi] = (r_pend != 2'd0);
    end

    assign bus.wb_ready = w_ready;
    assign bus.reg_en   = r_reg_en;
    assign bus.d_out    = r_d_out;
    assign bus.en_out   = r_en_out;
    assign bus.busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback
// Description : Self-checking bench for reg_writeback. Accepted pushes queue
//               their expected register write; a negedge monitor pops and
//               compares every write the DUT presents. Direct checks cover
//               reset values, readiness and the busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;
    typedef struct packed {
        logic [1:0]  rd;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    reg_writeback_if #(.DATA_W(16), .NREG(4)) bus ();

    reg_writeback #(.DATA_W(16), .NREG(4), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [1:0] rd, input logic [15:0] data, input bit expect_write);
        exp_t e;
        bus.en_in   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = data;
        if (expect_write) begin
            e.rd   = rd;
            e.data = data;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every presented write must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (bus.en_out || (bus.reg_en != 4'b0000))) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: reg_en=%b d_out=%h, expected no write",
                         bus.reg_en, bus.d_out);
            end else begin
                e = exp_q.pop_front();
                check("write", {11'd0, bus.en_out, bus.reg_en, bus.d_out},
                      {11'd0, 1'b1, 4'b0001 << e.rd, e.data});
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst          = 1'b0;
        bus.en_in    = 1'b0;
        bus.wb_rd    = 2'd0;
        bus.wb_data  = 16'h0000;
        bus.issue_en = 1'b0;
        bus.issue_rd = 2'd0;
        bus.stall    = 1'b0;

        repeat (2) tick();
        check("reset_reg_en", {28'd0, bus.reg_en}, 32'h0);
        check("reset_d_out",  {16'd0, bus.d_out},  32'h0);
        check("reset_en_out", {31'd0, bus.en_out}, 32'h0);
        check("reset_busy",   {28'd0, bus.busy},   32'h0);
        check("reset_ready",  {31'd0, bus.wb_ready}, 32'h1);
        rst = 1'b1;
        tick();

        // Single write latency
        bus.issue_en = 1'b1; bus.issue_rd = 2'd2;
        tick();                                   // edge 0
        bus.issue_en = 1'b0;
        check("lat_busy_set", {28'd0, bus.busy}, 32'h4);
        drive_push(2'd2, 16'hBEEF, 1'b1);
        tick();                                   // edge 1
        bus.en_in = 1'b0;
        check("lat_no_bypass", {31'd0, bus.en_out}, 32'h0);
        tick();                                   // edge 2
        check("lat_present", {11'd0, bus.en_out, bus.reg_en, bus.d_out}, {11'd0, 1'b1, 4'b0100, 16'hBEEF});
        tick();                                   // edge 3
        check("lat_busy_clr", {28'd0, bus.busy}, 32'h0);

        // Full buffer and backpressure
        bus.stall = 1'b1;
        drive_push(2'd0, 16'h0001, 1'b1);
        tick();
        drive_push(2'd1, 16'h0002, 1'b1);
        tick();
        check("full_ready", {31'd0, bus.wb_ready}, 32'h0);
        drive_push(2'd3, 16'h0003, 1'b0);          // must be dropped
        tick();
        bus.en_in = 1'b0;
        check("stall_no_write", {31'd0, bus.en_out}, 32'h0);
        bus.stall = 1'b0;
        tick();
        check("drain_ready", {31'd0, bus.wb_ready}, 32'h1);
        tick();
        check("drain_second", {31'd0, bus.en_out}, 32'h1);
        tick();
        check("drain_idle", {31'd0, bus.en_out}, 32'h0);

        // Continuous streaming
        for (int i = 0; i < 4; i++) begin
            check("stream_ready", {31'd0, bus.wb_ready}, 32'h1);
            drive_push(2'(i), 16'h0010 + 16'(i), 1'b1);
            tick();
            if (i > 0) check("stream_cont", {31'd0, bus.en_out}, 32'h1);
        end
        bus.en_in = 1'b0;
        repeat (3) tick();

        // Same-register ordering and pending count of two
        bus.issue_en = 1'b1; bus.issue_rd = 2'd1;
        repeat (2) tick();
        bus.issue_en = 1'b0;
        check("same_busy", {28'd0, bus.busy}, 32'h2);
        drive_push(2'd1, 16'hAAAA, 1'b1);
        tick();
        drive_push(2'd1, 16'h5555, 1'b1);
        tick();
        bus.en_in = 1'b0;
        tick();                                   // first commit
        check("same_busy_mid", {31'd0, bus.busy[1]}, 32'h1);
        tick();                                   // second commit
        check("same_busy_end", {31'd0, bus.busy[1]}, 32'h0);

        // Simultaneous increment and decrement on r3
        bus.issue_en = 1'b1; bus.issue_rd = 2'd3;
        tick();
        bus.issue_en = 1'b0;
        drive_push(2'd3, 16'h1234, 1'b1);
        tick();
        bus.en_in = 1'b0;
        tick();                                   // reg_en[3] now presented
        bus.issue_en = 1'b1; bus.issue_rd = 2'd3;
        tick();                                   // commit and reserve together
        bus.issue_en = 1'b0;
        check("incdec_busy", {31'd0, bus.busy[3]}, 32'h1);
        drive_push(2'd3, 16'h4321, 1'b1);
        tick();
        bus.en_in = 1'b0;
        tick();
        check("incdec_busy_hold", {31'd0, bus.busy[3]}, 32'h1);
        tick();
        check("incdec_busy_clr", {31'd0, bus.busy[3]}, 32'h0);

        // Saturation: four reservations of r0 leave a count of three
        bus.issue_en = 1'b1; bus.issue_rd = 2'd0;
        repeat (4) tick();
        bus.issue_en = 1'b0;
        check("sat_busy", {28'd0, bus.busy}, 32'h1);
        drive_push(2'd0, 16'h0A01, 1'b1);
        tick();
        drive_push(2'd0, 16'h0A02, 1'b1);
        tick();
        drive_push(2'd0, 16'h0A03, 1'b1);
        tick();
        bus.en_in = 1'b0;
        tick();
        check("sat_busy_two_commits", {31'd0, bus.busy[0]}, 32'h1);
        tick();
        check("sat_busy_clr", {31'd0, bus.busy[0]}, 32'h0);
        tick();

        // Reset mid-operation with buffered entries and reservations
        bus.issue_en = 1'b1; bus.issue_rd = 2'd0;
        tick();
        bus.issue_rd = 2'd2;
        tick();
        bus.issue_en = 1'b0;
        bus.stall = 1'b1;
        drive_push(2'd1, 16'h0B01, 1'b0);
        tick();
        drive_push(2'd3, 16'h0B02, 1'b0);
        tick();
        bus.en_in = 1'b0;
        check("prereset_ready", {31'd0, bus.wb_ready}, 32'h0);
        check("prereset_busy",  {28'd0, bus.busy},     32'h5);
        rst = 1'b0;
        #2;
        check("midreset_reg_en", {28'd0, bus.reg_en},   32'h0);
        check("midreset_d_out",  {16'd0, bus.d_out},    32'h0);
        check("midreset_en_out", {31'd0, bus.en_out},   32'h0);
        check("midreset_busy",   {28'd0, bus.busy},     32'h0);
        check("midreset_ready",  {31'd0, bus.wb_ready}, 32'h1);
        tick();
        rst = 1'b1;
        bus.stall = 1'b0;
        repeat (4) begin
            tick();
            check("postreset_idle", {31'd0, bus.en_out}, 32'h0);
        end
        drive_push(2'd2, 16'hCAFE, 1'b1);
        tick();
        bus.en_in = 1'b0;

        // Bounded drain of any outstanding expectations
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
